// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: load-stream framing constants
// and the loader state encoding.
package imem_loader_pkg;

   localparam int unsigned HdrBytes  = 2;
   localparam int unsigned CountW    = 8 * HdrBytes;
   localparam int unsigned WordBytes = 4;

   typedef enum logic [2:0] {
      StHdr0 = 3'd0,
      StHdr1 = 3'd1,
      StData = 3'd2,
      StDone = 3'd3,
      StErr  = 3'd4
   } ld_state_e;

   // States in which the loader is still consuming stream bytes.
   function automatic logic accepts(input ld_state_e s);
      return (s == StHdr0) || (s == StHdr1) || (s == StData);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; flags the push that completes a word
// and presents the finished word (including that final byte) in the same cycle.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [7:0]               data_i,
   output logic [8*WordBytes-1:0]   word_o,
   output logic                     word_done_o
);

   localparam int unsigned IdxW = $clog2(WordBytes);

   logic [IdxW-1:0]          idx_q, idx_d;
   logic [8*WordBytes-1:0]   asm_q, asm_d;

   always_comb begin
      idx_d = idx_q;
      asm_d = asm_q;
      if (push_i) begin
         asm_d[{idx_q, 3'b000} +: 8] = data_i;
         idx_d                       = idx_q + 1'b1;
      end
   end

   assign word_o      = asm_d;
   assign word_done_o = push_i && (idx_q == IdxW'(WordBytes - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
         asm_q <= '0;
      end else begin
         idx_q <= idx_d;
         asm_q <= asm_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a count-prefixed byte stream into instruction-memory writes and holds
// the cpu in reset until every word has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   ld_state_e          state_q, state_d;
   logic [CountW-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               we_q, we_d;

   logic               xfer;
   logic               push;
   logic               word_done;
   logic [31:0]        word;
   logic [CountW-1:0]  cnt_full;
   logic               last_word;

   assign in_ready = !rst && accepts(state_q);
   assign xfer     = in_valid && in_ready;
   assign push     = xfer && (state_q == StData);
   assign cnt_full = {in_data, cnt_q[7:0]};

   // addr_q has already advanced past the previous write by the time a word completes.
   assign last_word = (CountW'(addr_q) == cnt_q - CountW'(1));

   byte_packer u_packer (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (push),
      .data_i      (in_data),
      .word_o      (word),
      .word_done_o (word_done)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;

      // Saturate so the address never points past the last memory word.
      if (we_q && (addr_q != ADDR_W'(DEPTH - 1))) begin
         addr_d = addr_q + 1'b1;
      end

      unique case (state_q)
         StHdr0: begin
            if (xfer) begin
               cnt_d[7:0] = in_data;
               state_d    = StHdr1;
            end
         end
         StHdr1: begin
            if (xfer) begin
               cnt_d = cnt_full;
               if (cnt_full == '0) begin
                  state_d = StDone;
               end else if (32'(cnt_full) > DEPTH) begin
                  state_d = StErr;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (word_done) begin
               we_d    = 1'b1;
               wdata_d = word;
               if (last_word) begin
                  state_d = StDone;
               end
            end
         end
         StDone, StErr: begin
            state_d = state_q;
         end
         default: begin
            state_d = StHdr0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StHdr0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // Release waits for the final write strobe to retire.
   assign mem_we    = we_q && !rst;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done      = !rst && (state_q == StDone) && !we_q;
   assign err       = !rst && (state_q == StErr);
   assign cpu_rst   = !done;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH SHALL default to 64 and set the instruction-memory size in 32-bit words.
REQ-003 Parameter ADDR_W SHALL default to clog2(DEPTH) and set the word-address width.
REQ-004 Port clk SHALL be an input, 1 bit wide, and act as the system clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, and act as the synchronous, active-high reset.
REQ-006 Port in_valid SHALL be an input, 1 bit wide, and mark the byte on in_data as valid.
REQ-007 Port in_data SHALL be an input, 8 bits wide, and carry the load-stream byte.
REQ-008 Port in_ready SHALL be an output, 1 bit wide, and show that the loader accepts a byte this cycle.
REQ-009 Port mem_we SHALL be an output, 1 bit wide, and act as the instruction-memory write strobe.
REQ-010 Port mem_addr SHALL be an output, ADDR_W bits wide, and carry the instruction-memory word address.
REQ-011 Port mem_wdata SHALL be an output, 32 bits wide, and carry the instruction word to write.
REQ-012 Port cpu_rst SHALL be an output, 1 bit wide, and hold the cpu's rst input high until loading completes.
REQ-013 Port done SHALL be an output, 1 bit wide, and show that the load completed and the cpu is released.
REQ-014 Port err SHALL be an output, 1 bit wide, and show that the header word count exceeded DEPTH.

Function
REQ-015 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both 1; otherwise nothing changes.
REQ-016 Stream format SHALL be a 2-byte little-endian count N, then N instruction words of 4 little-endian bytes each.
REQ-017 The state machine SHALL have the states HDR0, HDR1, DATA, DONE and ERR.
REQ-018 HDR0 SHALL capture N[7:0] on a transfer and move to HDR1.
REQ-019 HDR1 SHALL capture N[15:8] on a transfer and then move to: DONE if N=0; ERR if N>DEPTH; DATA otherwise.
REQ-020 in_ready SHALL be 1 in HDR0, HDR1 and DATA, and 0 in DONE and ERR.
REQ-021 In DATA, a 2-bit byte index SHALL place byte k into bits [8k+7:8k] of the assembly register.
REQ-022 On transfer of byte index 3, the assembled word SHALL load into mem_wdata and mem_we SHALL be 1 for exactly the next cycle.
REQ-023 mem_addr SHALL equal the word index, starting at 0 and incrementing after each mem_we pulse.
REQ-024 The loader SHALL accept a new byte in the same cycle mem_we is high, with no bubble required.
REQ-025 On transfer of the final byte of word N-1, state SHALL move to DONE; mem_we is high in the first DONE cycle.
REQ-026 cpu_rst SHALL deassert and done SHALL assert 2 cycles after the final byte transfer, one cycle after the last mem_we.
REQ-027 For N=0, cpu_rst SHALL fall and done SHALL rise 1 cycle after the HDR1 transfer, and mem_we SHALL never pulse.
REQ-028 ERR SHALL hold cpu_rst=1, err=1 and mem_we=0, and ERR and DONE SHALL be left only by rst.
REQ-029 mem_addr SHALL never exceed DEPTH-1; N=DEPTH is legal.

Reset
REQ-030 While rst=1: state=HDR0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, and byte and word counters SHALL be 0.
REQ-031 Reset asserted mid-load SHALL abort the load immediately with no further mem_we, and SHALL leave memory contents untouched.
REQ-032 in_ready SHALL rise in the first cycle after rst falls.

Structure
REQ-033 State encodings and the header byte count SHALL live in the shared femto defines header.
REQ-034 The byte-to-word assembly (index counter, shift-in register, word-complete pulse) SHALL be one sub-module named byte_packer.
REQ-035 The loader SHALL instantiate in the top level between the stream source and the cpu, driving the cpu's rst and the instruction-memory write port.

Verification
REQ-036 Scenario: stream 02 00, EF BE AD DE, 13 00 00 00 -> writes (addr 0, DEADBEEF), (addr 1, 00000013); done=1 two cycles after the last byte.
REQ-037 Scenario: stream 00 00 -> no mem_we, and cpu_rst falls one cycle after the second byte.
REQ-038 Scenario: count 41 00 with DEPTH=64 -> err=1, in_ready=0, cpu_rst stays 1, and no writes occur.
REQ-039 Scenario: N=DEPTH with in_valid held high every cycle -> 64 writes with addresses 0..63, one per 4 cycles, and in_ready never drops during DATA.
REQ-040 Scenario: in_valid toggled randomly -> the word sequence is identical to the back-to-back case.
REQ-041 Scenario: rst pulsed after 5 data bytes -> outputs return to reset values, and a reload from HDR0 writes from addr 0.
